// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready target with programmable wait states,
// byte-masked stores, full-word loads and misaligned/out-of-range error reporting.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : '0;

  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_check
    $error("dmem_responder: LATENCY %0d outside legal range 0..15", LATENCY);
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_idle;
  logic                w_accept;
  logic                w_commit;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [BE_W-1:0]     w_be;
  logic [ADDR_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_idx;
  logic                w_misal;
  logic                w_oor;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_wmask;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = req_valid && w_idle;

  // With zero wait states the commit happens on the accept edge itself, so the
  // access is taken straight from the request inputs instead of the capture regs.
  assign w_commit = ((r_state == ST_WAIT) && (r_cnt == '0)) || (ZERO_LAT && w_accept);
  assign w_we     = w_idle ? req_we    : r_we;
  assign w_addr   = w_idle ? req_addr  : r_addr;
  assign w_wdata  = w_idle ? req_wdata : r_wdata;
  assign w_be     = w_idle ? req_be    : r_be;

  assign w_word   = w_addr >> OFF_W;
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_misal  = (w_addr & ADDR_W'(BE_W - 1)) != '0;
  assign w_oor    = w_word >= ADDR_W'(DEPTH_WORDS);
  assign w_err    = w_misal || w_oor;
  assign w_rdata  = r_mem[w_idx];

  for (genvar b = 0; b < BE_W; b++) begin : g_mask
    assign w_wmask[8*b +: 8] = {8{w_be[b]}};
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_state     <= ST_RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_we || w_err) ? '0 : w_rdata;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (!ZERO_LAT) begin
              r_state <= ST_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 1, 3, 0) driven
// one at a time, checked against a word-array reference model.
module tb_dmem_responder;

  localparam int NI = 3;

  typedef struct {
    int          k;
    logic [31:0] data;
    bit          known;
    bit          err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  logic [31:0] mdl   [NI][256];
  bit          known [NI][256];
  bit   rnd_on = 1'b0;
  int   cur_k = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 0);

    dmem_responder #(
      .DATA_W(32),
      .ADDR_W(32),
      .DEPTH_WORDS(256),
      .LATENCY(LAT)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be(req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g])
    );

    bit          in_rsp = 1'b0;
    bit          exp_idle = 1'b0;
    logic [31:0] hd;
    logic        he;
    exp_t        e;

    initial begin
      forever begin
        @(negedge clk);
        if (rst) begin
          in_rsp   = 1'b0;
          exp_idle = 1'b0;
        end else begin
          if (exp_idle) begin
            chk($sformatf("lat%0d idle req_ready", LAT), 32'(req_ready[g]), 32'd1);
            chk($sformatf("lat%0d idle rsp_valid", LAT), 32'(rsp_valid[g]), 32'd0);
            chk($sformatf("lat%0d idle rsp_rdata", LAT), rsp_rdata[g], 32'd0);
            chk($sformatf("lat%0d idle rsp_err", LAT), 32'(rsp_err[g]), 32'd0);
            exp_idle = 1'b0;
          end
          if (rsp_valid[g]) begin
            if (!in_rsp) begin
              if (sbq.size() == 0 || sbq[0].k != g) begin
                n_tests++;
                n_fail++;
                $display("FAIL lat%0d unexpected_rsp: rsp_valid=1 expected no response pending", LAT);
              end else begin
                e = sbq.pop_front();
                chk($sformatf("lat%0d latency", LAT), 32'(cyc - e.acc), 32'(LAT + 1));
                chk($sformatf("lat%0d rsp_err", LAT), 32'(rsp_err[g]), 32'(e.err));
                if (e.known) chk($sformatf("lat%0d rsp_rdata", LAT), rsp_rdata[g], e.data);
              end
              hd     = rsp_rdata[g];
              he     = rsp_err[g];
              in_rsp = 1'b1;
            end else begin
              chk($sformatf("lat%0d hold rdata", LAT), rsp_rdata[g], hd);
              chk($sformatf("lat%0d hold err", LAT), 32'(rsp_err[g]), 32'(he));
            end
            chk($sformatf("lat%0d busy req_ready", LAT), 32'(req_ready[g]), 32'd0);
            if (rsp_ready[g]) begin
              in_rsp   = 1'b0;
              exp_idle = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_on) rsp_ready[cur_k] = ($urandom % 3) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at 500000 expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic set_rdy(input int k, input logic v);
    @(posedge clk);
    #1;
    rsp_ready[k] = v;
  endtask

  // Presents one request, waits (bounded) for the accept edge and records the
  // response the model expects unless the transaction is to be discarded.
  task automatic issue(input int k, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit drop, output int acc);
    int          n;
    int unsigned idx;
    bit          er;
    logic [31:0] m;
    exp_t        e;
    n = 0;
    @(negedge clk);
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout inst%0d: req_ready=0 expected 1 within 200 cycles", k);
      req_valid[k] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (!drop) begin
      idx     = a >> 2;
      er      = (a[1:0] != 2'b00) || (idx >= 256);
      e.k     = k;
      e.acc   = acc;
      e.err   = er;
      e.known = 1'b1;
      e.data  = '0;
      if (!er && we) begin
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        mdl[k][idx[7:0]] = (mdl[k][idx[7:0]] & ~m) | (wd & m);
        if (be == 4'hF) known[k][idx[7:0]] = 1'b1;
      end else if (!er) begin
        e.data  = mdl[k][idx[7:0]];
        e.known = known[k][idx[7:0]];
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while ((sbq.size() != 0 || rsp_valid[k]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout inst%0d: response still pending expected done within 300 cycles", k);
    end
    @(negedge clk);
  endtask

  initial begin
    int          acc;
    int          prev;
    int          r;
    int unsigned w;
    logic [31:0] a;
    logic [3:0]  be;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      req_be[k]    = '0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("inst%0d reset req_ready", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("inst%0d reset rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("inst%0d reset rsp_rdata", k), rsp_rdata[k], 32'd0);
      chk($sformatf("inst%0d reset rsp_err", k), 32'(rsp_err[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rsp_ready[k] = 1'b1;

    for (int k = 0; k < NI; k++) begin
      for (int unsigned i = 0; i < 16; i++) issue(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, acc);
      drain(k);
    end

    // LATENCY=1: basic store/load, byte-masked merge, error cases and top word
    issue(0, 1'b1, 32'h0, 32'd15, 4'hF, 1'b0, acc);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, acc);
    issue(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'hF, 1'b0, acc);
    issue(0, 1'b1, 32'h4, 32'h11223344, 4'b0101, 1'b0, acc);
    issue(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, acc);
    issue(0, 1'b0, 32'h6, 32'h0, 4'hF, 1'b0, acc);
    issue(0, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, acc);
    issue(0, 1'b1, 32'h6, 32'hDEADBEEF, 4'hF, 1'b0, acc);
    issue(0, 1'b1, 32'h400, 32'hDEADBEEF, 4'hF, 1'b0, acc);
    issue(0, 1'b1, 32'hFFFF_FFF0, 32'hDEADBEEF, 4'hF, 1'b0, acc);
    issue(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 1'b0, acc);
    issue(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, acc);
    issue(0, 1'b1, 32'h3FC, 32'h5A5A_1234, 4'hF, 1'b0, acc);
    issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, acc);
    drain(0);

    // LATENCY=3: response held under back-pressure
    set_rdy(1, 1'b0);
    issue(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, acc);
    repeat (9) @(negedge clk);
    set_rdy(1, 1'b1);
    drain(1);

    // LATENCY=3: reset during WAIT discards the uncommitted store
    issue(1, 1'b1, 32'h8, 32'h0, 4'hF, 1'b0, acc);
    drain(1);
    issue(1, 1'b1, 32'h8, 32'h77, 4'hF, 1'b1, acc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-wait reset req_ready", 32'(req_ready[1]), 32'd1);
    chk("mid-wait reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, acc);
    drain(1);

    // LATENCY=0: back-to-back with rsp_ready tied high
    prev = -1;
    for (int unsigned i = 0; i < 10; i++) begin
      issue(2, 1'b1, 32'((32 + i) * 4), $urandom, 4'hF, 1'b0, acc);
      if (prev >= 0) chk("lat0 accept spacing", 32'(acc - prev), 32'd2);
      prev = acc;
      issue(2, 1'b0, 32'((32 + i) * 4), $urandom, 4'($urandom), 1'b0, acc);
      chk("lat0 accept spacing", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    drain(2);

    // randomized traffic with random back-pressure on each instance
    for (int k = 0; k < NI; k++) begin
      cur_k  = k;
      rnd_on = 1'b1;
      for (int i = 0; i < 60; i++) begin
        r = int'($urandom % 16);
        w = $urandom % 16;
        if (r < 12)       a = 32'(w * 4);
        else if (r == 12) a = 32'(w * 4 + 1 + ($urandom % 3));
        else if (r == 13) a = 32'h3FC;
        else if (r == 14) a = 32'h400 + 32'(w * 4);
        else              a = $urandom | 32'h0001_0000;
        be = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
        issue(k, 1'($urandom), a, $urandom, be, 1'b0, acc);
      end
      rnd_on = 1'b0;
      set_rdy(k, 1'b1);
      drain(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
